// File: rtl/reg_access_arbiter.sv
// Two-requester arbiter around a shared WIDTH-bit register supporting parallel
// load and MSB-first rotating shift-out; all state updates on the falling clock edge.
module reg_access_arbiter #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req0,
  input  logic             op0,
  input  logic [WIDTH-1:0] d0,
  input  logic             req1,
  input  logic             op1,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             busy_q, busy_d;
  logic             sout_q, sout_d;
  logic             sv_q, sv_d;
  logic             done_q, done_d;

  logic             grant0, grant1, any_grant, sel_op, last_shift;
  logic [WIDTH-1:0] sel_d;

  // last_q == 1 means requester 1 held the most recent grant.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (req0 && req1) begin
        grant0 = last_q;
        grant1 = !last_q;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  assign any_grant  = grant0 | grant1;
  assign sel_op     = grant1 ? op1 : op0;
  assign sel_d      = grant1 ? d1 : d0;
  assign last_shift = (cnt_q == CW'(WIDTH - 1));

  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      data_q  <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
      sout_q  <= 1'b0;
      sv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      data_q  <= data_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      busy_q  <= busy_d;
      sout_q  <= sout_d;
      sv_q    <= sv_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_grant && sel_op) state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs; sout holds its last shifted bit between transfers.
  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    data_d = data_q;
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    busy_d = busy_q;
    sout_d = sout_q;
    sv_d   = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_grant) begin
          gnt0_d = grant0;
          gnt1_d = grant1;
          last_d = grant1;
          if (!sel_op) begin
            data_d = sel_d;
            done_d = 1'b1;
          end else begin
            busy_d = 1'b1;
            cnt_d  = '0;
          end
        end
      end
      SHIFT: begin
        sout_d = data_q[WIDTH-1];
        data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        sv_d   = 1'b1;
        if (last_shift) begin
          done_d = 1'b1;
          busy_d = 1'b0;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign busy       = busy_q;
  assign q          = data_q;
  assign sout       = sout_q;
  assign sout_valid = sv_q;
  assign done       = done_q;

endmodule

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
- Controller and arbiter that shares one WIDTH-bit D-flip-flop register between two requesters.
- Each requester asks for one of two operations:
  - parallel load: register takes the requester's data in one cycle;
  - serial shift-out: register contents stream out MSB-first over WIDTH cycles, rotating so contents are preserved.
- Sits between client logic and the register datapath; the register itself lives inside this block.
- All state updates on the falling edge of clk, matching the team's register cells.

Parameters:
- WIDTH, 4, register width in bits (>=2).
- CW, $clog2(WIDTH)+1, shift-counter width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the falling edge.
- clr  in  1  asynchronous active-low reset (clear).
- req0  in  1  requester 0 request; held high until gnt0 is seen.
- op0  in  1  requester 0 operation: 0 = load, 1 = shift-out.
- d0  in  WIDTH  requester 0 load data.
- req1  in  1  requester 1 request.
- op1  in  1  requester 1 operation.
- d1  in  WIDTH  requester 1 load data.
- gnt0  out  1  one-cycle grant pulse to requester 0.
- gnt1  out  1  one-cycle grant pulse to requester 1.
- busy  out  1  high while a shift-out transfer is in progress.
- q  out  WIDTH  current register contents.
- sout  out  1  serial output bit.
- sout_valid  out  1  sout carries a valid bit this cycle.
- done  out  1  one-cycle pulse when an operation completes.

Behaviour:
- Reset (clr=0, asynchronous, any time, including mid-shift):
  - q=0, gnt0=gnt1=0, busy=0, sout=0, sout_valid=0, done=0;
  - state=IDLE, shift count=0, last_grant=1 (requester 0 wins the first contested grant).
- Pulse outputs: gnt0, gnt1, sout_valid and done are registered and deasserted on every edge unless set by the rules below.
- States: IDLE, SHIFT.
- IDLE, no request: hold q; all pulses 0.
- IDLE, exactly one req high: grant it.
- IDLE, both req high: grant the requester other than last_grant (round-robin).
- At a grant edge:
  - gnt_x=1 and last_grant=x;
  - op_x and d_x are sampled at this edge only.
- Grant with op=0 (load):
  - q<=d_x and done=1 at the same edge;
  - state remains IDLE, so a new grant is possible at the very next edge (back-to-back loads, one per cycle).
- Grant with op=1 (shift-out): state<=SHIFT, busy<=1, count<=0; q unchanged.
- SHIFT, each edge:
  - sout<=q[WIDTH-1], q<=rotate-left(q) (q[0]<=q[WIDTH-1]), sout_valid<=1, count<=count+1.
- SHIFT, the edge where count==WIDTH-1:
  - performs the last shift as above;
  - done<=1, busy<=0, state<=IDLE.
- Shift timing:
  - a shift transfer spans WIDTH+1 edges, grant included;
  - the earliest next grant is the edge after done is asserted;
  - after WIDTH rotations q equals its pre-shift value.
- Requests during SHIFT: ignored (no grant, nothing sampled); the requester keeps req high.
- Requests and last_grant: a requester that drops req before its grant is simply not served; last_grant updates only on an actual grant.
- op/d stability: changes to op or d while not granted have no effect.
- No WIDTH arithmetic overflow: count never exceeds WIDTH-1.

Test Plan:
- Reset values: hold clr=0, toggle clk, drive req0=req1=1 -> q=0, all outputs 0; release clr -> first grant goes to req0.
- Single load: req1=1, op1=0, d1=4'b1010 -> gnt1=1 and done=1 at the same falling edge, q=1010, busy stays 0.
- Contention: req0 (op=0, d=0011) and req1 (op=0, d=0101) held high for 4 edges -> grants alternate 0,1,0,1; q after each edge: 0011, 0101, 0011, 0101.
- Shift-out: q=1011, req0 op0=1:
  - gnt0 on edge 0; sout=1,0,1,1 with sout_valid on edges 1-4;
  - done and busy fall on edge 4; q=1011 afterwards.
- Request during shift: req1 load d1=1111 asserted on edge 2 of a shift -> no gnt1 until edge 5; q=1111 at edge 5.
- Reset mid-operation: clr low between edges 2 and 3 of a shift -> q, sout, sout_valid, busy, done go 0 immediately (no clock); after release, state is IDLE and a new shift request is accepted normally.
